// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter for the CPU-to-PC serial link. The bus pushes
//   bytes into a small FIFO. A shifter empties the FIFO onto PC_Uart_txd,
//   LSB first, with one start bit and one stop bit. Everything runs on sysclk.
//   An internal divider holds each bit for BAUD_DIV cycles.
//
//   Optional build macro: UART_TX_PARITY_EN
//     defined   -> 8E1 frames. An even-parity bit follows the data bits
//                  (11 bit times).
//     undefined -> 8N1 frames (10 bit times). No parity logic is built.
//
// Parameters
//   BAUD_DIV    sysclk cycles per UART bit (2..65535)
//   FIFO_DEPTH  TX FIFO entries, power of two (2..256)
//   ADDR_W      log2(FIFO_DEPTH)
//
// Ports
//   sysclk       in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   TX_DATA      in   byte to enqueue
//   TX_WR        in   enqueue strobe, one byte per high cycle
//   TX_FULL      out  FIFO holds FIFO_DEPTH bytes
//   TX_EMPTY     out  FIFO holds no bytes
//   TX_COUNT     out  FIFO occupancy 0..FIFO_DEPTH
//   TX_OVF       out  sticky: a write was dropped on a full FIFO
//   TX_STATUS    out  1 when the FIFO is empty and the shifter is idle
//   PC_Uart_txd  out  registered serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 10417,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [7:0]        TX_DATA,
    input  logic              TX_WR,
    output logic              TX_FULL,
    output logic              TX_EMPTY,
    output logic [ADDR_W:0]   TX_COUNT,
    output logic              TX_OVF,
    output logic              TX_STATUS,
    output logic              PC_Uart_txd
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = (ADDR_W)'(1);
    localparam logic [15:0]       BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

    // ---------------- FIFO ----------------
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              ovf_reg;
    logic              push;
    logic              pop;

    // The full flag is registered, so a push is judged against the occupancy
    // before this cycle's pop. A write on a full FIFO is dropped even if a
    // slot frees on the same edge.
    assign push = TX_WR && !full_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (TX_WR && full_reg) begin
                ovf_reg <= 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= TX_DATA;
        end
    end

    // ---------------- Shifter ----------------
    state_t      state_reg;
    state_t      state_next;
    logic [15:0] baud_cnt_reg;
    logic [15:0] baud_cnt_next;
    logic [2:0]  bit_idx_reg;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift_reg;
    logic        shift_en;
    logic        txd_reg;
    logic        txd_next;
    logic        status_reg;
    logic        baud_last;
`ifdef UART_TX_PARITY_EN
    logic        parity_reg;
`endif

    assign baud_last = (baud_cnt_reg == BAUD_LAST);

    // The popped byte is captured into the shift register (the registered
    // RAM read). From then on the frame is independent of later FIFO writes.
    always_ff @(posedge sysclk) begin
        if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
        end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    // The parity accumulates as each data bit leaves. After 8 shifts it
    // holds the XOR of the byte.
    always_ff @(posedge sysclk) begin
        if (pop) begin
            parity_reg <= 1'b0;
        end else if (shift_en) begin
            parity_reg <= parity_reg ^ shift_reg[0];
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg + 16'd1;
        bit_idx_next  = bit_idx_reg;
        pop           = 1'b0;
        shift_en      = 1'b0;
        txd_next      = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                if (!empty_reg) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                txd_next = 1'b0;
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_next = shift_reg[0];
                if (baud_last) begin
                    baud_cnt_next = '0;
                    shift_en      = 1'b1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_next = parity_reg;
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                txd_next = 1'b1;
                if (baud_last) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!empty_reg) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    // The line register follows the state one cycle later. Every bit,
    // including the start bit, is still exactly BAUD_DIV cycles wide.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            txd_reg      <= 1'b1;
            status_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            txd_reg      <= txd_next;
            status_reg   <= empty_reg && (state_reg == ST_IDLE);
        end
    end

    assign TX_FULL     = full_reg;
    assign TX_EMPTY    = empty_reg;
    assign TX_COUNT    = count_reg;
    assign TX_OVF      = ovf_reg;
    assign TX_STATUS   = status_reg;
    assign PC_Uart_txd = txd_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with BAUD_DIV=4 and FIFO_DEPTH=4.
//   A vector table checks single-byte frames cycle by cycle.
//   Hand-written sequences cover:
//     - a back-to-back burst
//     - FIFO overflow
//     - a push on a full FIFO in the same cycle as a pop
//     - a reset in the middle of a frame
//   A line monitor decodes frames into a queue, which the sequences use to
//   check the received bytes.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int B  = 4;
    localparam int D  = 4;
    localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic          sysclk  = 1'b0;
    logic          reset   = 1'b1;
    logic          TX_WR   = 1'b0;
    logic [7:0]    TX_DATA = 8'h00;
    logic          TX_FULL;
    logic          TX_EMPTY;
    logic [AW:0]   TX_COUNT;
    logic          TX_OVF;
    logic          TX_STATUS;
    logic          PC_Uart_txd;

    uart_tx_fifo #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D),
        .ADDR_W     (AW)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .TX_DATA     (TX_DATA),
        .TX_WR       (TX_WR),
        .TX_FULL     (TX_FULL),
        .TX_EMPTY    (TX_EMPTY),
        .TX_COUNT    (TX_COUNT),
        .TX_OVF      (TX_OVF),
        .TX_STATUS   (TX_STATUS),
        .PC_Uart_txd (PC_Uart_txd)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit i of a frame is the line level during bit time i.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    // ---------------- line monitor ----------------
    logic [7:0]  rx_q[$];
    int          rx_err = 0;
    bit          mbusy  = 1'b0;
    int          mcnt   = 0;
    logic [10:0] mbits  = '0;

    always @(negedge sysclk) begin
        if (reset) begin
            mbusy = 1'b0;
        end else if (!mbusy) begin
            if (PC_Uart_txd == 1'b0) begin
                mbusy = 1'b1;
                mcnt  = 0;
            end
        end else begin
            mcnt++;
            if (mcnt % B == B / 2) begin
                mbits[mcnt / B] = PC_Uart_txd;
                if (mcnt / B == FB - 1) begin
                    rx_q.push_back(mbits[8:1]);
                    if (mbits[0] != 1'b0 || mbits[FB-1] != 1'b1) rx_err++;
`ifdef UART_TX_PARITY_EN
                    if (mbits[9] != ^mbits[8:1]) rx_err++;
`endif
                    mbusy = 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        TX_WR = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int limit);
        int n = 0;
        while (TX_STATUS !== 1'b1 && n < limit) begin
            @(negedge sysclk);
            n++;
        end
        chk(name, 32'(TX_STATUS), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t tbl[8];
    int   base;
    int   err0;
    int   low_cnt;
    int   exp_cnt[6];
    int   exp_ovf[6];
    logic [7:0] bb[3];

    initial begin
`ifdef UART_TX_PARITY_EN
        tbl[0] = '{8'hA5, 11'b10_10100101_0};
        tbl[1] = '{8'h00, 11'b10_00000000_0};
        tbl[2] = '{8'hFF, 11'b10_11111111_0};
        tbl[3] = '{8'h01, 11'b11_00000001_0};
        tbl[4] = '{8'h80, 11'b11_10000000_0};
        tbl[5] = '{8'h3C, 11'b10_00111100_0};
        tbl[6] = '{8'h07, 11'b11_00000111_0};
        tbl[7] = '{8'h03, 11'b10_00000011_0};
`else
        tbl[0] = '{8'hA5, 11'b01_10100101_0};
        tbl[1] = '{8'h00, 11'b01_00000000_0};
        tbl[2] = '{8'hFF, 11'b01_11111111_0};
        tbl[3] = '{8'h01, 11'b01_00000001_0};
        tbl[4] = '{8'h80, 11'b01_10000000_0};
        tbl[5] = '{8'h3C, 11'b01_00111100_0};
        tbl[6] = '{8'h07, 11'b01_00000111_0};
        tbl[7] = '{8'h03, 11'b01_00000011_0};
`endif
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        exp_ovf = '{0, 0, 0, 0, 0, 1};

        // ---- reset state ----
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        chk("rst_txd",    32'(PC_Uart_txd), 32'd1);
        chk("rst_status", 32'(TX_STATUS),   32'd1);
        chk("rst_empty",  32'(TX_EMPTY),    32'd1);
        chk("rst_full",   32'(TX_FULL),     32'd0);
        chk("rst_count",  32'(TX_COUNT),    32'd0);
        chk("rst_ovf",    32'(TX_OVF),      32'd0);
        $display("reset state checked");

        // ---- table: single frames, cycle-exact ----
        for (int i = 0; i < 8; i++) begin
            TX_DATA = tbl[i].data;
            TX_WR   = 1'b1;
            @(negedge sysclk);
            TX_WR = 1'b0;
            chk($sformatf("v%0d_empty_after_push", i), 32'(TX_EMPTY), 32'd0);
            chk($sformatf("v%0d_count_after_push", i), 32'(TX_COUNT), 32'd1);
            chk($sformatf("v%0d_status_push_edge", i), 32'(TX_STATUS), 32'd1);
            @(negedge sysclk);
            chk($sformatf("v%0d_txd_pop_edge", i), 32'(PC_Uart_txd), 32'd1);
            chk($sformatf("v%0d_status_busy", i), 32'(TX_STATUS), 32'd0);
            @(negedge sysclk);
            for (int c = 0; c < FB * B; c++) begin
                chk($sformatf("v%0d_frame_c%0d", i, c), 32'(PC_Uart_txd),
                    32'(tbl[i].frame[c / B]));
                @(negedge sysclk);
            end
            chk($sformatf("v%0d_status_end", i), 32'(TX_STATUS), 32'd1);
            chk($sformatf("v%0d_count_end", i), 32'(TX_COUNT), 32'd0);
            $display("vector %0d data=%02h frame checked", i, tbl[i].data);
        end

        // ---- burst: three back-to-back frames, no idle gap ----
        bb = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) begin
            TX_DATA = bb[i];
            TX_WR   = 1'b1;
            @(negedge sysclk);
        end
        TX_WR = 1'b0;
        for (int c = 0; c < 3 * FB * B; c++) begin
            logic [10:0] fr;
            fr = frame_of(bb[c / (FB * B)]);
            chk($sformatf("burst_c%0d", c), 32'(PC_Uart_txd),
                32'(fr[(c % (FB * B)) / B]));
            if (c == 3 * FB * B - 1) chk("burst_status_last", 32'(TX_STATUS), 32'd0);
            @(negedge sysclk);
        end
        chk("burst_status_end", 32'(TX_STATUS), 32'd1);
        $display("burst 01 02 03 checked");

        // ---- overflow: six back-to-back writes from idle ----
        do_reset();
        base = rx_q.size();
        err0 = rx_err;
        for (int i = 0; i < 6; i++) begin
            TX_DATA = 8'h10 + 8'(i);
            TX_WR   = 1'b1;
            @(negedge sysclk);
            chk($sformatf("ovf_count_w%0d", i), 32'(TX_COUNT), 32'(exp_cnt[i]));
            chk($sformatf("ovf_flag_w%0d", i), 32'(TX_OVF), 32'(exp_ovf[i]));
            if (i == 4) chk("ovf_full_w4", 32'(TX_FULL), 32'd1);
        end
        TX_WR = 1'b0;
        wait_quiet("ovf_drain", 6 * FB * B + 20);
        chk("ovf_rx_count", 32'(rx_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("ovf_rx%0d", i), 32'(rx_q[base+i]), 32'h10 + 32'(i));
        end
        chk("ovf_rx_frame_err", 32'(rx_err - err0), 32'd0);
        chk("ovf_sticky", 32'(TX_OVF), 32'd1);
        $display("overflow sequence checked");

        // ---- push on full in the same cycle as the STOP pop ----
        do_reset();
        base = rx_q.size();
        err0 = rx_err;
        for (int i = 0; i < 5; i++) begin
            TX_DATA = 8'h20 + 8'(i);
            TX_WR   = 1'b1;
            @(negedge sysclk);
        end
        TX_WR = 1'b0;
        chk("pf_full", 32'(TX_FULL), 32'd1);
        chk("pf_count_full", 32'(TX_COUNT), 32'd4);
        repeat (FB * B - 4) @(negedge sysclk);
        chk("pf_count_pre", 32'(TX_COUNT), 32'd4);
        chk("pf_ovf_pre", 32'(TX_OVF), 32'd0);
        TX_DATA = 8'hEE;
        TX_WR   = 1'b1;
        @(negedge sysclk);
        TX_WR = 1'b0;
        chk("pf_count_post", 32'(TX_COUNT), 32'd3);
        chk("pf_ovf_post", 32'(TX_OVF), 32'd1);
        chk("pf_full_post", 32'(TX_FULL), 32'd0);
        wait_quiet("pf_drain", 5 * FB * B + 20);
        chk("pf_rx_count", 32'(rx_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("pf_rx%0d", i), 32'(rx_q[base+i]), 32'h20 + 32'(i));
        end
        chk("pf_rx_frame_err", 32'(rx_err - err0), 32'd0);
        $display("push-on-full with pop checked");

        // ---- reset during data bit 3 ----
        do_reset();
        TX_DATA = 8'h5A;
        TX_WR   = 1'b1;
        @(negedge sysclk);
        TX_DATA = 8'hC3;
        @(negedge sysclk);
        TX_WR = 1'b0;
        @(negedge sysclk);
        chk("mid_start_bit", 32'(PC_Uart_txd), 32'd0);
        repeat (17) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        chk("mid_txd",    32'(PC_Uart_txd), 32'd1);
        chk("mid_count",  32'(TX_COUNT),    32'd0);
        chk("mid_status", 32'(TX_STATUS),   32'd1);
        chk("mid_empty",  32'(TX_EMPTY),    32'd1);
        low_cnt = 0;
        repeat (3 * FB * B) begin
            @(negedge sysclk);
            if (PC_Uart_txd !== 1'b1) low_cnt++;
        end
        chk("mid_no_frame", 32'(low_cnt), 32'd0);
        chk("mid_status_hold", 32'(TX_STATUS), 32'd1);
        $display("reset mid-frame checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
